// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues req/ack reads for the PC register's address and queues {PC, word} for decode.
// Define FETCH_PIPELINE_EN to allow the next request to be issued in the same cycle as the current ack.
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        Branch,
    input  logic        stall,
    output logic        FetchStall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t        state_reg, state_next;
    logic          req_reg, req_next;
    logic [31:0]   addr_reg, addr_next;
    logic [CW-1:0] count_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;

    logic [31:0]   instr_mem [QDEPTH];
    logic [31:0]   pc_mem    [QDEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (count_reg != '0);

    // Space is reserved when a request is issued, so a push can never overflow.
    always_comb begin
        pop    = not_empty && !stall && !Branch;
        push   = (state_reg == REQ) && IMemAck && !Branch;
        accept = (state_reg == IDLE) && (count_reg < DEPTH_C) && !Branch;
`ifdef FETCH_PIPELINE_EN
        if (push && ((count_reg + CW'(1) - CW'(pop)) < DEPTH_C)) begin
            accept = 1'b1;
        end
`endif
    end

    assign FetchStall = reset || !accept;

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next  = PC;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (IMemAck) begin
                    if (accept) begin
                        addr_next = PC;
                    end else begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end else if (Branch) begin
                    // A request is never withdrawn; wait out its ack and drop the data.
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (IMemAck) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= RESET_PC;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
        end
    end

    assign IMemReq  = req_reg;
    assign IMemAddr = addr_reg;

    // Flush on Branch takes priority over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (Branch) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= IMemData;
            pc_mem[wr_ptr_reg]    <= addr_reg;
        end
    end

    assign InstrValid = not_empty;
    assign Instr      = not_empty ? instr_mem[rd_ptr_reg] : '0;
    assign InstrPC    = not_empty ? pc_mem[rd_ptr_reg] : RESET_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/flush scenarios plus a randomized scoreboard run.
// The bench models the PC register and a req/ack instruction memory around the DUT.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic        Branch;
    logic        stall;
    logic        FetchStall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;

    fetch_unit #(.QDEPTH(2), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Branch     (Branch),
        .stall      (stall),
        .FetchStall (FetchStall),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int fails  = 0;

    // Environment state: PC register model, memory responder, per-cycle inputs.
    logic        rst_in;
    logic [31:0] pc_reg;
    logic        br;
    logic [31:0] br_target;
    logic        stall_in;
    int          resp_mode;      // 0 fixed delay, 1 random 0-5, 2 manual
    int          fixed_delay;
    logic        ack_manual;
    logic        resp_busy;
    int          resp_wait;
    int          resp_delay;
    logic [31:0] resp_addr;

    // Values sampled just before the active edge of the last tick.
    logic        s_fs, s_req, s_ack, s_valid, s_pop, s_addr_held;
    logic [31:0] s_addr, s_instr, s_ipc;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic tick();
        logic ack;
        @(negedge clk);
        reset  = rst_in;
        PC     = pc_reg;
        Branch = br;
        stall  = stall_in;
        if (IMemReq && !resp_busy && !rst_in) begin
            resp_busy  = 1'b1;
            resp_wait  = 0;
            resp_delay = (resp_mode == 1) ? int'($urandom_range(0, 5)) : fixed_delay;
            resp_addr  = IMemAddr;
        end
        if (rst_in)
            ack = 1'b0;
        else if (resp_mode == 2)
            ack = IMemReq && ack_manual;
        else
            ack = IMemReq && resp_busy && (resp_wait == resp_delay);
        IMemAck  = ack;
        IMemData = ack ? word(IMemAddr) : 32'hDEAD_BEEF;
        #1;
        s_fs        = FetchStall;
        s_req       = IMemReq;
        s_addr      = IMemAddr;
        s_ack       = IMemAck;
        s_valid     = InstrValid;
        s_instr     = Instr;
        s_ipc       = InstrPC;
        s_pop       = s_valid && !stall_in && !br;
        s_addr_held = !s_req || (s_addr == resp_addr);
        @(posedge clk);
        #1;
        if (rst_in) begin
            pc_reg    = RPC;
            resp_busy = 1'b0;
        end else begin
            if (br)
                pc_reg = br_target;
            else if (!s_fs)
                pc_reg = pc_reg + 32'd4;
            if (s_ack)
                resp_busy = 1'b0;
            else if (resp_busy)
                resp_wait++;
        end
    endtask

    task automatic do_reset();
        rst_in      = 1'b1;
        br          = 1'b0;
        stall_in    = 1'b0;
        ack_manual  = 1'b0;
        resp_mode   = 0;
        fixed_delay = 0;
        resp_busy   = 1'b0;
        pc_reg      = RPC;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (IMemReq !== 1'b0)   begin fails++; $display("FAIL reset_req: got %b want 0", IMemReq); end
        if (FetchStall !== 1'b1) begin fails++; $display("FAIL reset_fstall: got %b want 1", FetchStall); end
        if (InstrValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
        if (IMemAddr !== RPC)   begin fails++; $display("FAIL reset_addr: got %h want %h", IMemAddr, RPC); end
        if (InstrPC !== RPC)    begin fails++; $display("FAIL reset_ipc: got %h want %h", InstrPC, RPC); end
        tick();
        checks += 3;
        if (s_fs !== 1'b0)      begin fails++; $display("FAIL release_fstall: got %b want 0", s_fs); end
        if (IMemReq !== 1'b1)   begin fails++; $display("FAIL first_req: got %b want 1", IMemReq); end
        if (IMemAddr !== RPC)   begin fails++; $display("FAIL first_addr: got %h want %h", IMemAddr, RPC); end
        // Reset asserted in the middle of an outstanding request.
        reset = 1'b1;
        PC    = RPC;
        #2;
        checks += 3;
        if (IMemReq !== 1'b0)   begin fails++; $display("FAIL midreset_req: got %b want 0", IMemReq); end
        if (InstrValid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want 0", InstrValid); end
        if (FetchStall !== 1'b1) begin fails++; $display("FAIL midreset_fstall: got %b want 1", FetchStall); end
        rst_in    = 1'b1;
        resp_busy = 1'b0;
        pc_reg    = RPC;
        tick();
        rst_in = 1'b0;
        tick();
        checks += 3;
        if (s_fs !== 1'b0 || s_req !== 1'b0) begin fails++; $display("FAIL rerelease: fstall %b req %b want 0 0", s_fs, s_req); end
        if (IMemReq !== 1'b1)   begin fails++; $display("FAIL rereq: got %b want 1", IMemReq); end
        if (IMemAddr !== RPC)   begin fails++; $display("FAIL readdr: got %h want %h", IMemAddr, RPC); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        logic [31:0] pq[$];
        logic [31:0] iq[$];
        int nvalid = 0;
        int exp_valid;
`ifdef FETCH_PIPELINE_EN
        exp_valid = 6;
`else
        exp_valid = 3;
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_valid) nvalid++;
            if (s_pop) begin pq.push_back(s_ipc); iq.push_back(s_instr); end
        end
        checks++;
        if (nvalid !== exp_valid) begin fails++; $display("FAIL zw_throughput: got %0d valid cycles want %0d", nvalid, exp_valid); end
        checks++;
        if (pq.size() < 3) begin
            fails++;
            $display("FAIL zw_count: got %0d pops want >=3", pq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (pq[i] !== RPC + 32'(4 * i)) begin fails++; $display("FAIL zw_pc%0d: got %h want %h", i, pq[i], RPC + 32'(4 * i)); end
                if (iq[i] !== word(RPC + 32'(4 * i))) begin fails++; $display("FAIL zw_instr%0d: got %h want %h", i, iq[i], word(RPC + 32'(4 * i))); end
            end
        end
        $display("test_zero_wait done: %0d valid cycles, %0d pops", nvalid, pq.size());
    endtask

    task automatic test_stall_fill();
        logic [31:0] pq[$];
        logic [31:0] iq[$];
        do_reset();
        stall_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks += 4;
        if (s_fs !== 1'b1)    begin fails++; $display("FAIL full_fstall: got %b want 1", s_fs); end
        if (s_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", s_valid); end
        if (s_req !== 1'b0)   begin fails++; $display("FAIL full_req: got %b want 0", s_req); end
        if (s_ipc !== RPC)    begin fails++; $display("FAIL full_head: got %h want %h", s_ipc, RPC); end
        stall_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_pop) begin pq.push_back(s_ipc); iq.push_back(s_instr); end
        end
        checks++;
        if (pq.size() < 3) begin
            fails++;
            $display("FAIL drain_count: got %0d pops want >=3", pq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (pq[i] !== RPC + 32'(4 * i)) begin fails++; $display("FAIL drain_pc%0d: got %h want %h", i, pq[i], RPC + 32'(4 * i)); end
                if (iq[i] !== word(RPC + 32'(4 * i))) begin fails++; $display("FAIL drain_instr%0d: got %h want %h", i, iq[i], word(RPC + 32'(4 * i))); end
            end
        end
        $display("test_stall_fill done: %0d pops after release", pq.size());
    endtask

    task automatic test_branch_discard();
        logic found = 1'b0;
        logic got   = 1'b0;
        do_reset();
        fixed_delay = 2;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (s_req && s_addr == 32'h0040_0010) found = 1'b1;
        end
        checks++;
        if (!found) begin fails++; $display("FAIL discard_issue: request for 00400010 not seen within 200 cycles"); end
        br        = 1'b1;
        br_target = 32'h0040_0220;
        tick();
        br = 1'b0;
        checks += 3;
        if (IMemReq !== 1'b1)            begin fails++; $display("FAIL discard_hold_req: got %b want 1", IMemReq); end
        if (IMemAddr !== 32'h0040_0010) begin fails++; $display("FAIL discard_hold_addr: got %h want 00400010", IMemAddr); end
        if (InstrValid !== 1'b0)         begin fails++; $display("FAIL discard_flush: got %b want 0", InstrValid); end
        tick();
        checks += 2;
        if (IMemReq !== 1'b0)            begin fails++; $display("FAIL discard_done_req: got %b want 0", IMemReq); end
        if (InstrValid !== 1'b0)         begin fails++; $display("FAIL discard_drop: got %b want 0", InstrValid); end
        tick();
        checks += 2;
        if (IMemReq !== 1'b1)            begin fails++; $display("FAIL redirect_req: got %b want 1", IMemReq); end
        if (IMemAddr !== 32'h0040_0220) begin fails++; $display("FAIL redirect_addr: got %h want 00400220", IMemAddr); end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (s_valid) begin
                got = 1'b1;
                checks += 2;
                if (s_ipc !== 32'h0040_0220) begin fails++; $display("FAIL redirect_ipc: got %h want 00400220", s_ipc); end
                if (s_instr !== word(32'h0040_0220)) begin fails++; $display("FAIL redirect_instr: got %h want %h", s_instr, word(32'h0040_0220)); end
            end
        end
        checks++;
        if (!got) begin fails++; $display("FAIL redirect_timeout: no instruction within 20 cycles"); end
        $display("test_branch_discard done");
    endtask

    task automatic test_branch_ack_pop();
        logic found = 1'b0;
        do_reset();
        resp_mode  = 2;
        stall_in   = 1'b1;
        ack_manual = 1'b0;
        tick();
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_req) found = 1'b1;
        end
        checks++;
        if (!found) begin fails++; $display("FAIL bap_setup: second request not seen"); end
        ack_manual = 1'b1;
        br         = 1'b1;
        br_target  = 32'h0040_0300;
        stall_in   = 1'b0;
        tick();
        br         = 1'b0;
        ack_manual = 1'b0;
        checks += 3;
        if (s_valid !== 1'b1 || s_ack !== 1'b1) begin fails++; $display("FAIL bap_pre: valid %b ack %b want 1 1", s_valid, s_ack); end
        if (InstrValid !== 1'b0) begin fails++; $display("FAIL bap_valid: got %b want 0", InstrValid); end
        if (IMemReq !== 1'b0)    begin fails++; $display("FAIL bap_req: got %b want 0", IMemReq); end
        tick();
        checks += 3;
        if (s_fs !== 1'b0)       begin fails++; $display("FAIL bap_idle: fstall %b want 0", s_fs); end
        if (s_valid !== 1'b0)    begin fails++; $display("FAIL bap_empty: got %b want 0", s_valid); end
        if (IMemAddr !== 32'h0040_0300 || IMemReq !== 1'b1) begin fails++; $display("FAIL bap_next: req %b addr %h want 1 00400300", IMemReq, IMemAddr); end
        $display("test_branch_ack_pop done");
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int npop = 0;
        int nbr  = 0;
        do_reset();
        resp_mode = 1;
        exp_pc    = RPC;
        for (int i = 0; i < 1000; i++) begin
            stall_in = ($urandom_range(0, 99) < 30);
            br       = ($urandom_range(0, 99) < 4);
            if (br) begin
                br_target = RPC + ($urandom_range(0, 4095) << 2);
                nbr++;
            end
            tick();
            if (s_pop) begin
                checks++;
                if (s_ipc !== exp_pc || s_instr !== word(exp_pc)) begin
                    fails++;
                    $display("FAIL rand_pop cycle %0d: got pc %h instr %h want pc %h instr %h", i, s_ipc, s_instr, exp_pc, word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                npop++;
            end
            if (br) exp_pc = br_target;
            if (s_req) begin
                checks++;
                if (!s_addr_held) begin fails++; $display("FAIL rand_addr_stable cycle %0d: got %h want %h", i, s_addr, resp_addr); end
            end
        end
        br       = 1'b0;
        stall_in = 1'b0;
        checks++;
        if (npop < 100) begin fails++; $display("FAIL rand_progress: got %0d pops want >=100", npop); end
        $display("test_random done: %0d pops, %0d branches", npop, nbr);
    endtask

    initial begin
        reset     = 1'b1;
        PC        = RPC;
        Branch    = 1'b0;
        stall     = 1'b0;
        IMemAck   = 1'b0;
        IMemData  = 32'h0;
        rst_in    = 1'b1;
        pc_reg    = RPC;
        br        = 1'b0;
        br_target = RPC;
        stall_in  = 1'b0;
        resp_mode = 0;
        fixed_delay = 0;
        ack_manual  = 1'b0;
        resp_busy   = 1'b0;
        resp_wait   = 0;
        resp_delay  = 0;
        resp_addr   = RPC;
        test_reset();
        test_zero_wait();
        test_stall_fill();
        test_branch_discard();
        test_branch_ack_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
